// File: rtl/irq_timer.sv
// irq_timer: 64-bit machine timer (mtime/mtimecmp with prescaler) and external IRQ sync/latch
// Ports: i_clk/i_rst clock and async active-high reset; i_ext_irq async external request;
//        i_cs/i_we/i_addr/i_wdata/o_rdata single-cycle word bus; o_t_irq/o_e_irq level IRQs to CSR.
module irq_timer #(
  parameter int PRESC_W  = 8,
  parameter bit EXT_EDGE = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ext_irq,
  input  logic        i_cs,
  input  logic        i_we,
  input  logic [4:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_t_irq,
  output logic        o_e_irq
);
  logic [63:0]        mtime_q, mtime_d, cmp_q, cmp_d;
  logic [31:0]        shadow_q, shadow_d, sel;
  logic [PRESC_W-1:0] presc_q, presc_d, div_q, div_d;
  logic               en_q, en_d, s1_q, s2_q, s3_q, pend_q, pend_d, tirq_q;
  logic [2:0]         a;
  logic               wr, rd, tick, clr;
  logic               unused_addr;
  assign unused_addr = ^i_addr[1:0];
  assign a    = i_addr[4:2];
  assign wr   = i_cs & i_we;
  assign rd   = i_cs & ~i_we;
  assign tick = en_q && (div_q == presc_q);
  assign clr  = wr && a == 3'd5 && i_wdata[0];
  always_comb begin
    div_d    = en_q ? (tick ? '0 : div_q + 1'b1) : div_q;
    // a bus write to either half wins over a tick in the same cycle
    mtime_d  = (wr && a == 3'd0) ? {mtime_q[63:32], i_wdata} :
               (wr && a == 3'd1) ? {i_wdata, mtime_q[31:0]} :
               tick ? mtime_q + 64'd1 : mtime_q;
    cmp_d    = (wr && a == 3'd2) ? {cmp_q[63:32], i_wdata} :
               (wr && a == 3'd3) ? {i_wdata, cmp_q[31:0]} : cmp_q;
    en_d     = (wr && a == 3'd4) ? i_wdata[0] : en_q;
    presc_d  = (wr && a == 3'd4) ? i_wdata[8 +: PRESC_W] : presc_q;
    // snapshot the high half on a LO read so a LO-then-HI pair is carry-atomic
    shadow_d = (rd && a == 3'd0) ? mtime_q[63:32] : shadow_q;
    // set beats W1C when both happen in the same cycle
    pend_d   = EXT_EDGE ? ((s2_q & ~s3_q) | (pend_q & ~clr)) : s2_q;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mtime_q  <= '0;
      cmp_q    <= '1;
      en_q     <= 1'b0;
      presc_q  <= '0;
      div_q    <= '0;
      shadow_q <= '0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      pend_q   <= 1'b0;
      tirq_q   <= 1'b0;
    end else begin
      mtime_q  <= mtime_d;
      cmp_q    <= cmp_d;
      en_q     <= en_d;
      presc_q  <= presc_d;
      div_q    <= div_d;
      shadow_q <= shadow_d;
      s1_q     <= i_ext_irq;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      pend_q   <= pend_d;
      tirq_q   <= mtime_q >= cmp_q;
    end
  end
  always_comb begin
    sel = (a == 3'd0) ? mtime_q[31:0] :
          (a == 3'd1) ? shadow_q :
          (a == 3'd2) ? cmp_q[31:0] :
          (a == 3'd3) ? cmp_q[63:32] :
          (a == 3'd4) ? ((32'(presc_q) << 8) | {31'b0, en_q}) :
          (a == 3'd5) ? {30'b0, tirq_q, pend_q} : 32'h0;
  end
  assign o_rdata = rd ? sel : 32'h0;
  assign o_t_irq = tirq_q;
  assign o_e_irq = pend_q;
endmodule
